// File: rtl/gravity_pkg.sv
// Shared constants for the centroid post-processing path: sum widths,
// fixed-point format, controller state encoding and divider length.
package gravity_pkg;

  localparam int SUM_S_WIDTH   = 20;
  localparam int SUM_SXY_WIDTH = 28;
  localparam int FRAC_BITS     = 4;
  localparam int COORD_WIDTH   = 10;

  // One quotient bit per cycle over the whole shifted dividend.
  function automatic int calc_iter(input int sxy_w, input int frac_w);
    return sxy_w + frac_w;
  endfunction

  localparam int ITER = calc_iter(SUM_SXY_WIDTH, FRAC_BITS);

  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    DIV_X   = 3'd1,
    DIV_Y   = 3'd2,
    PRESENT = 3'd3
  } state_e;

endpackage

// File: rtl/seq_restoring_div.sv
// Sequential restoring divider: one quotient bit per cycle, ITER iterations,
// then a one-cycle oDONE pulse while oQUOT holds the truncated quotient.
// A new iSTART is only taken while idle; the caller owns sequencing.
module seq_restoring_div #(
  parameter int SUM_S_WIDTH = gravity_pkg::SUM_S_WIDTH,
  parameter int ITER        = gravity_pkg::ITER
) (
  input  logic                   CCLK,
  input  logic                   RST_N,
  input  logic                   iSTART,
  input  logic [ITER-1:0]        iDIVIDEND,
  input  logic [SUM_S_WIDTH-1:0] iDIVISOR,
  output logic                   oDONE,
  output logic [ITER-1:0]        oQUOT
);

  localparam int DW    = ITER + 1;
  localparam int CNT_W = $clog2(ITER + 1);

  logic [ITER-1:0]  rem_q, rem_d;
  logic [ITER-1:0]  quo_q, quo_d;
  logic [DW-1:0]    dvs_q, dvs_d;
  logic [DW-1:0]    trial;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             busy_q, busy_d;
  logic             done_q, done_d;

  // Shift-subtract step while busy; load operands on an accepted start.
  always_comb begin
    rem_d  = rem_q;
    quo_d  = quo_q;
    dvs_d  = dvs_q;
    cnt_d  = cnt_q;
    busy_d = busy_q;
    done_d = 1'b0;
    trial  = {rem_q, quo_q[ITER-1]};
    if (busy_q) begin
      if (trial >= dvs_q) begin
        rem_d = ITER'(trial - dvs_q);
        quo_d = {quo_q[ITER-2:0], 1'b1};
      end else begin
        rem_d = trial[ITER-1:0];
        quo_d = {quo_q[ITER-2:0], 1'b0};
      end
      cnt_d = cnt_q - 1'b1;
      if (cnt_q == CNT_W'(1)) begin
        busy_d = 1'b0;
        done_d = 1'b1;
      end
    end else if (iSTART) begin
      rem_d  = '0;
      quo_d  = iDIVIDEND;
      dvs_d  = DW'(iDIVISOR);
      cnt_d  = CNT_W'(ITER);
      busy_d = 1'b1;
    end
  end

  // Divider state registers.
  always_ff @(posedge CCLK or negedge RST_N) begin
    if (!RST_N) begin
      rem_q  <= '0;
      quo_q  <= '0;
      dvs_q  <= '0;
      cnt_q  <= '0;
      busy_q <= 1'b0;
      done_q <= 1'b0;
    end else begin
      rem_q  <= rem_d;
      quo_q  <= quo_d;
      dvs_q  <= dvs_d;
      cnt_q  <= cnt_d;
      busy_q <= busy_d;
      done_q <= done_d;
    end
  end

  assign oDONE = done_q;
  assign oQUOT = quo_q;

endmodule

// File: rtl/gravity_div_sched.sv
// Centroid post-processing controller: captures S/SX/SY on the trigger's
// rising edge, time-shares one divider for CX then CY, and presents the
// result on a valid/ready port while BUSY brackets the whole frame.
module gravity_div_sched #(
  parameter int SUM_S_WIDTH   = gravity_pkg::SUM_S_WIDTH,
  parameter int SUM_SXY_WIDTH = gravity_pkg::SUM_SXY_WIDTH,
  parameter int FRAC_BITS     = gravity_pkg::FRAC_BITS,
  parameter int COORD_WIDTH   = gravity_pkg::COORD_WIDTH
) (
  input  logic                             CCLK,
  input  logic                             RST_N,
  input  logic                             iSTART_TRIG,
  input  logic [SUM_S_WIDTH-1:0]           iSUM_S,
  input  logic [SUM_SXY_WIDTH-1:0]         iSUM_SX,
  input  logic [SUM_SXY_WIDTH-1:0]         iSUM_SY,
  output logic                             oBUSY,
  output logic                             oVALID,
  input  logic                             iREADY,
  output logic [COORD_WIDTH+FRAC_BITS-1:0] oCX,
  output logic [COORD_WIDTH+FRAC_BITS-1:0] oCY,
  output logic                             oNO_TARGET,
  output logic                             oOVERRUN,
  output logic [2:0]                       oSTATE
);

  import gravity_pkg::*;

  localparam int IT    = calc_iter(SUM_SXY_WIDTH, FRAC_BITS);
  localparam int OUT_W = COORD_WIDTH + FRAC_BITS;

  state_e                   state_q, state_d;
  logic                     trig_q;
  logic                     start_ev;
  logic [SUM_S_WIDTH-1:0]   s_q, s_d;
  logic [SUM_SXY_WIDTH-1:0] sx_q, sx_d, sy_q, sy_d;
  logic                     launch_q, launch_d;
  logic                     busy_q, busy_d;
  logic                     valid_q, valid_d;
  logic [OUT_W-1:0]         cx_q, cx_d, cy_q, cy_d;
  logic                     nt_q, nt_d;
  logic                     ovr_q, ovr_d;

  logic                     div_start;
  logic [IT-1:0]            div_dividend;
  logic                     div_done;
  logic [IT-1:0]            div_quot;

  // Anything that does not fit the coordinate format clamps to all ones.
  function automatic logic [OUT_W-1:0] sat_coord(input logic [IT-1:0] q);
    if (|q[IT-1:OUT_W]) return '1;
    return q[OUT_W-1:0];
  endfunction

  assign start_ev = iSTART_TRIG & ~trig_q;

  // Frame sequencing, divider sharing and result presentation.
  always_comb begin
    state_d      = state_q;
    s_d          = s_q;
    sx_d         = sx_q;
    sy_d         = sy_q;
    launch_d     = 1'b0;
    busy_d       = busy_q;
    valid_d      = valid_q;
    cx_d         = cx_q;
    cy_d         = cy_q;
    nt_d         = nt_q;
    ovr_d        = start_ev && (state_q != IDLE);
    div_start    = launch_q;
    // The Y operand goes in on the same cycle the X quotient comes out.
    div_dividend = div_done ? {sy_q, {FRAC_BITS{1'b0}}}
                            : {sx_q, {FRAC_BITS{1'b0}}};
    case (state_q)
      IDLE: begin
        if (start_ev) begin
          s_d    = iSUM_S;
          sx_d   = iSUM_SX;
          sy_d   = iSUM_SY;
          busy_d = 1'b1;
          if (iSUM_S != '0) begin
            state_d  = DIV_X;
            launch_d = 1'b1;
          end else begin
            state_d = PRESENT;
            cx_d    = '0;
            cy_d    = '0;
            nt_d    = 1'b1;
          end
        end
      end
      DIV_X: begin
        if (div_done) begin
          cx_d      = sat_coord(div_quot);
          div_start = 1'b1;
          state_d   = DIV_Y;
        end
      end
      DIV_Y: begin
        if (div_done) begin
          cy_d    = sat_coord(div_quot);
          valid_d = 1'b1;
          nt_d    = 1'b0;
          state_d = PRESENT;
        end
      end
      PRESENT: begin
        // The no-target path enters here with valid still low.
        if (!valid_q) begin
          valid_d = 1'b1;
        end else if (iREADY) begin
          valid_d = 1'b0;
          busy_d  = 1'b0;
          state_d = IDLE;
        end
      end
      default: begin
        state_d = IDLE;
        busy_d  = 1'b0;
        valid_d = 1'b0;
        cx_d    = '0;
        cy_d    = '0;
        nt_d    = 1'b0;
        ovr_d   = 1'b0;
      end
    endcase
  end

  // Controller registers.
  always_ff @(posedge CCLK or negedge RST_N) begin
    if (!RST_N) begin
      state_q  <= IDLE;
      trig_q   <= 1'b0;
      s_q      <= '0;
      sx_q     <= '0;
      sy_q     <= '0;
      launch_q <= 1'b0;
      busy_q   <= 1'b0;
      valid_q  <= 1'b0;
      cx_q     <= '0;
      cy_q     <= '0;
      nt_q     <= 1'b0;
      ovr_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      trig_q   <= iSTART_TRIG;
      s_q      <= s_d;
      sx_q     <= sx_d;
      sy_q     <= sy_d;
      launch_q <= launch_d;
      busy_q   <= busy_d;
      valid_q  <= valid_d;
      cx_q     <= cx_d;
      cy_q     <= cy_d;
      nt_q     <= nt_d;
      ovr_q    <= ovr_d;
    end
  end

  seq_restoring_div #(
    .SUM_S_WIDTH (SUM_S_WIDTH),
    .ITER        (IT)
  ) u_div (
    .CCLK      (CCLK),
    .RST_N     (RST_N),
    .iSTART    (div_start),
    .iDIVIDEND (div_dividend),
    .iDIVISOR  (s_q),
    .oDONE     (div_done),
    .oQUOT     (div_quot)
  );

  assign oBUSY      = busy_q;
  assign oVALID     = valid_q;
  assign oCX        = cx_q;
  assign oCY        = cy_q;
  assign oNO_TARGET = nt_q;
  assign oOVERRUN   = ovr_q;
  assign oSTATE     = state_q;

endmodule

// File: tb/tb_gravity_div_sched.sv
// Directed bench for gravity_div_sched: a vector table of single frames with
// hand-computed results, plus hand-written backpressure, overrun, held
// trigger and mid-divide reset sequences.
module tb_gravity_div_sched;

  logic        CCLK = 1'b0;
  logic        RST_N = 1'b0;
  logic        iSTART_TRIG = 1'b0;
  logic [19:0] iSUM_S = '0;
  logic [27:0] iSUM_SX = '0;
  logic [27:0] iSUM_SY = '0;
  logic        oBUSY, oVALID;
  logic        iREADY = 1'b0;
  logic [13:0] oCX, oCY;
  logic        oNO_TARGET, oOVERRUN;
  logic [2:0]  oSTATE;

  int errors = 0;
  int checks = 0;

  gravity_div_sched dut (
    .CCLK        (CCLK),
    .RST_N       (RST_N),
    .iSTART_TRIG (iSTART_TRIG),
    .iSUM_S      (iSUM_S),
    .iSUM_SX     (iSUM_SX),
    .iSUM_SY     (iSUM_SY),
    .oBUSY       (oBUSY),
    .oVALID      (oVALID),
    .iREADY      (iREADY),
    .oCX         (oCX),
    .oCY         (oCY),
    .oNO_TARGET  (oNO_TARGET),
    .oOVERRUN    (oOVERRUN),
    .oSTATE      (oSTATE)
  );

  always #5 CCLK = ~CCLK;

  typedef struct {
    logic [19:0] s;
    logic [27:0] sx;
    logic [27:0] sy;
    logic [13:0] cx;
    logic [13:0] cy;
    logic        nt;
    int          lat;
  } vec_t;

  vec_t vecs[5];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  // Wait (bounded) for oVALID; returns cycles counted since the sample after T.
  task automatic wait_valid(output int lat);
    lat = 0;
    while (!oVALID && lat < 200) begin
      @(posedge CCLK); #1;
      lat++;
    end
    if (!oVALID) begin
      errors++;
      checks++;
      $display("FAIL wait_valid: oVALID never rose within 200 cycles");
    end
  endtask

  task automatic launch(input logic [19:0] s, input logic [27:0] sx, input logic [27:0] sy);
    @(negedge CCLK);
    iSUM_S = s; iSUM_SX = sx; iSUM_SY = sy;
    iSTART_TRIG = 1'b1;
    @(posedge CCLK); #1;
  endtask

  task automatic run_vec(input vec_t v);
    int lat;
    iREADY = 1'b1;
    launch(v.s, v.sx, v.sy);
    chk("busy_at_T", {31'd0, oBUSY}, 32'd1);
    wait_valid(lat);
    chk("latency", lat, v.lat);
    chk("cx", {18'd0, oCX}, {18'd0, v.cx});
    chk("cy", {18'd0, oCY}, {18'd0, v.cy});
    chk("no_target", {31'd0, oNO_TARGET}, {31'd0, v.nt});
    @(posedge CCLK); #1;
    chk("valid_drop", {31'd0, oVALID}, 32'd0);
    chk("busy_drop", {31'd0, oBUSY}, 32'd0);
    @(negedge CCLK);
    iSTART_TRIG = 1'b0;
  endtask

  initial begin
    int lat, nv, no;
    logic stable;
    logic [13:0] hcx, hcy;

    vecs[0] = '{s: 20'd4, sx: 28'd10,        sy: 28'd6,     cx: 14'h0028, cy: 14'h0018, nt: 1'b0, lat: 67};
    vecs[1] = '{s: 20'd0, sx: 28'd123,       sy: 28'd45,    cx: 14'h0000, cy: 14'h0000, nt: 1'b1, lat: 1};
    vecs[2] = '{s: 20'd1, sx: 28'hFFFFFFF,   sy: 28'd2,     cx: 14'h3FFF, cy: 14'h0020, nt: 1'b0, lat: 67};
    vecs[3] = '{s: 20'd7, sx: 28'd100,       sy: 28'd700,   cx: 14'h00E4, cy: 14'h0640, nt: 1'b0, lat: 67};
    vecs[4] = '{s: 20'd1, sx: 28'h3FF,       sy: 28'h400,   cx: 14'h3FF0, cy: 14'h3FFF, nt: 1'b0, lat: 67};

    // Reset state
    #1;
    chk("rst_busy", {31'd0, oBUSY}, 32'd0);
    chk("rst_valid", {31'd0, oVALID}, 32'd0);
    chk("rst_cx", {18'd0, oCX}, 32'd0);
    chk("rst_cy", {18'd0, oCY}, 32'd0);
    chk("rst_nt", {31'd0, oNO_TARGET}, 32'd0);
    chk("rst_ovr", {31'd0, oOVERRUN}, 32'd0);
    chk("rst_state", {29'd0, oSTATE}, 32'd0);
    repeat (3) @(posedge CCLK);
    @(negedge CCLK);
    RST_N = 1'b1;
    repeat (2) @(negedge CCLK);

    for (int i = 0; i < 5; i++) run_vec(vecs[i]);

    // Backpressure: result must hold while iREADY stays low.
    iREADY = 1'b0;
    launch(20'd4, 28'd10, 28'd6);
    wait_valid(lat);
    hcx = oCX; hcy = oCY;
    chk("bp_cx", {18'd0, hcx}, 32'h28);
    stable = 1'b1;
    for (int i = 0; i < 100; i++) begin
      @(posedge CCLK); #1;
      if (!oVALID || !oBUSY || oCX !== hcx || oCY !== hcy) stable = 1'b0;
    end
    chk("bp_stable", {31'd0, stable}, 32'd1);
    @(negedge CCLK);
    iREADY = 1'b1;
    @(posedge CCLK); #1;
    chk("bp_valid_drop", {31'd0, oVALID}, 32'd0);
    chk("bp_busy_drop", {31'd0, oBUSY}, 32'd0);
    chk("bp_cx_kept", {18'd0, oCX}, 32'h28);
    @(negedge CCLK);
    iSTART_TRIG = 1'b0;

    // Overrun: second edge during DIV_Y is dropped.
    launch(20'd5, 28'd50, 28'd25);
    repeat (40) @(posedge CCLK);
    #1;
    chk("ovr_in_divy", {29'd0, oSTATE}, 32'd2);
    @(negedge CCLK);
    iSTART_TRIG = 1'b0;
    @(negedge CCLK);
    iSTART_TRIG = 1'b1;
    iSUM_S = 20'd1; iSUM_SX = 28'd7; iSUM_SY = 28'd7;
    @(posedge CCLK); #1;
    chk("ovr_pulse", {31'd0, oOVERRUN}, 32'd1);
    @(posedge CCLK); #1;
    chk("ovr_one_cycle", {31'd0, oOVERRUN}, 32'd0);
    wait_valid(lat);
    chk("ovr_cx", {18'd0, oCX}, 32'hA0);
    chk("ovr_cy", {18'd0, oCY}, 32'h50);
    @(posedge CCLK); #1;
    @(negedge CCLK);
    iSTART_TRIG = 1'b0;
    repeat (2) @(negedge CCLK);

    // Trigger held high for 512 cycles: exactly one computation.
    iSUM_S = 20'd4; iSUM_SX = 28'd10; iSUM_SY = 28'd6;
    iSTART_TRIG = 1'b1;
    nv = 0; no = 0;
    for (int i = 0; i < 512; i++) begin
      @(posedge CCLK); #1;
      if (oVALID) nv++;
      if (oOVERRUN) no++;
    end
    chk("held_one_result", nv, 32'd1);
    chk("held_no_overrun", no, 32'd0);
    chk("held_idle", {31'd0, oBUSY}, 32'd0);
    @(negedge CCLK);
    iSTART_TRIG = 1'b0;
    @(negedge CCLK);

    // Reset during DIV_Y, then a clean frame.
    launch(20'd5, 28'd50, 28'd25);
    repeat (44) @(posedge CCLK);
    #1;
    chk("rst_mid_divy", {29'd0, oSTATE}, 32'd2);
    @(negedge CCLK);
    RST_N = 1'b0;
    iSTART_TRIG = 1'b0;
    #1;
    chk("rst_mid_busy", {31'd0, oBUSY}, 32'd0);
    chk("rst_mid_valid", {31'd0, oVALID}, 32'd0);
    chk("rst_mid_cx", {18'd0, oCX}, 32'd0);
    chk("rst_mid_state", {29'd0, oSTATE}, 32'd0);
    @(negedge CCLK);
    RST_N = 1'b1;
    launch(20'd3, 28'd30, 28'd9);
    wait_valid(lat);
    chk("post_rst_lat", lat, 32'd67);
    chk("post_rst_cx", {18'd0, oCX}, 32'hA0);
    chk("post_rst_cy", {18'd0, oCY}, 32'h30);
    @(negedge CCLK);
    iSTART_TRIG = 1'b0;
    repeat (3) @(posedge CCLK);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/gravity_div_sched.md
Name: gravity_div_sched

Overview:
Post-processing controller for the centroid accumulator. It captures the S/SX/SY sums when the accumulator's start trigger rises. It then time-shares one iterative divider, first for CX = (SX<<FRAC_BITS)/S and then for CY = (SY<<FRAC_BITS)/S. Results are presented on a valid/ready port to the output formatter. A BUSY level back to the accumulator brackets the whole operation, which lets the accumulator's wait states release.

Parameters:
SUM_S_WIDTH, 20, width of sum S (pixel count)
SUM_SXY_WIDTH, 28, width of SX and SY sums
FRAC_BITS, 4, fractional bits in quotients
COORD_WIDTH, 10, integer bits of a coordinate; output width is COORD_WIDTH+FRAC_BITS

Ports:
CCLK  in  1  clock
RST_N  in  1  asynchronous active-low reset
iSTART_TRIG  in  1  start level from accumulator; may stay high for many cycles, only its rising edge counts
iSUM_S  in  SUM_S_WIDTH  pixel count, stable when trigger rises
iSUM_SX  in  SUM_SXY_WIDTH  x-weighted sum
iSUM_SY  in  SUM_SXY_WIDTH  y-weighted sum
oBUSY  out  1  high from capture until result handshake completes
oVALID  out  1  result valid
iREADY  in  1  downstream accepts result
oCX  out  COORD_WIDTH+FRAC_BITS  centroid x, unsigned fixed point
oCY  out  COORD_WIDTH+FRAC_BITS  centroid y
oNO_TARGET  out  1  S was zero for this result
oOVERRUN  out  1  one-cycle pulse: trigger edge dropped while busy
oSTATE  out  3  debug, current state

Behaviour:
- Reset (async): every output is 0, state is IDLE, edge register is 0, captured operands are 0.
- Edge detection: trig_q registers iSTART_TRIG; a start event is iSTART_TRIG & ~trig_q.
- States (3-bit): IDLE=0, DIV_X=1, DIV_Y=2, PRESENT=3. Encodings 4..7 go to IDLE with outputs cleared.
- IDLE:
  - On a start event at posedge T, latch S, SX and SY. oBUSY=1 from T.
  - If S!=0: go to DIV_X and launch the divider on {SX, FRAC_BITS'0} / S.
  - If S==0: go straight to PRESENT with oCX=oCY=0 and oNO_TARGET=1. No divide.
- Divider:
  - Restoring, one quotient bit per cycle.
  - ITER = SUM_SXY_WIDTH+FRAC_BITS cycles (32 at defaults), plus one cycle for the done pulse.
  - Dividend width is ITER; divisor is zero-extended to ITER+1 bits. Remainder is discarded; result is truncated, not rounded.
- DIV_X: on divider done, register the saturated quotient into oCX, launch {SY, FRAC_BITS'0}/S, and go to DIV_Y.
- DIV_Y: on done, register the saturated quotient into oCY, set oVALID=1, oNO_TARGET=0, and go to PRESENT.
- Saturation: if any quotient bit at or above COORD_WIDTH+FRAC_BITS is set, the output is all ones.
- Latency: start edge at T, oVALID high from T+2*(ITER+1)+1 (T+67 at defaults). The S==0 path has oVALID from T+1.
- PRESENT:
  - oVALID, oCX, oCY and oNO_TARGET hold stable until iVALID&iREADY are sampled at a posedge (iREADY may be high early).
  - At that edge oVALID=0 and oBUSY=0 take effect together, and the state returns to IDLE.
  - oCX, oCY and oNO_TARGET keep their last values until the next result.
- A start event in any state other than IDLE is ignored. oOVERRUN pulses for one cycle and the captured operands are unchanged.
- A start event in IDLE in the same cycle oBUSY falls cannot happen: oBUSY falls on the IDLE-entry edge, so edges in the following cycle are accepted.
- Reset mid-operation aborts the divide. oBUSY and oVALID drop asynchronously.
- Throughput: one frame per 2*(ITER+1)+1+handshake cycles. This is well inside the accumulator's 512-cycle busy-rise and 4096-cycle busy-fall windows.

Decomposition:
- Shared package gravity_pkg holds:
  - SUM_S_WIDTH/SUM_SXY_WIDTH defaults (20/28), reused by the accumulator
  - FRAC_BITS and COORD_WIDTH
  - the state localparams IDLE/DIV_X/DIV_Y/PRESENT
  - ITER derivation
- One sub-module, seq_restoring_div:
  - ports: CCLK, RST_N, iSTART, iDIVIDEND[ITER], iDIVISOR[SUM_S_WIDTH], oDONE pulse, oQUOT[ITER]
  - behaviour: accepts iSTART only when idle; the controller owns sequencing and sharing.

Test Plan:
- S=4, SX=10, SY=6, FRAC=4, iREADY=1 -> oBUSY rises at T; oVALID at T+67 with oCX=0x0028, oCY=0x0018, oNO_TARGET=0; oBUSY/oVALID fall the next edge.
- S=0, SX=123, SY=45 -> oVALID at T+1, oCX=oCY=0, oNO_TARGET=1, no divider activity.
- S=1, SX=0xFFFFFFF, SY=2 -> oCX=0x3FFF (saturated), oCY=0x0020.
- iREADY held low 100 cycles after oVALID -> oVALID, oCX, oCY and oBUSY are stable throughout; release iREADY -> all drop one edge later.
- Second trigger edge during DIV_Y -> oOVERRUN 1-cycle pulse; result equals the first operand set; trigger held high 512 cycles gives exactly one computation.
- Assert RST_N low during DIV_Y -> all outputs 0 immediately; after release a new trigger computes correctly (S=3, SX=30 -> oCX=0x00A0).
